// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-side SRAM responder.
// Holds the FSM state encoding, bus transfer sizes and kseg0/kseg1 address masks.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // kseg0 (0x8...) and kseg1 (0xA...) share top bits 2'b10; both map to phys by clearing [31:29]
    localparam logic [1:0] KSEG_TOP2  = 2'b10;
    localparam logic [2:0] KSEG_CLEAR = 3'b000;

endpackage

// File: rtl/dmem_sram_responder_if.sv
// Core data port plus split-handshake memory bus seen by the responder.
// slave = responder view, master = core/hazard unit/bus environment view.
interface dmem_sram_responder_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_en;
    logic [3:0]    cpu_wen;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          longest_stall;

    logic          mem_req;
    logic          mem_wr;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok;
    logic          mem_data_ok;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_en, cpu_wen, cpu_addr, cpu_wdata, longest_stall,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output cpu_rdata, cpu_stall,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output cpu_en, cpu_wen, cpu_addr, cpu_wdata, longest_stall,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata
    );

endinterface

// File: rtl/dmem_size_enc.sv
// Maps a byte-write mask and address low bits to bus size, aligned addr[1:0] and write flag.
// Purely combinational; reads always go out as aligned words.
module dmem_size_enc
    import dmem_pkg::*;
(
    input  logic [3:0] i_wen,
    input  logic [1:0] i_addr_lo,
    output logic [1:0] o_size,
    output logic [1:0] o_addr_lo,
    output logic       o_wr
);

    logic w_unused_addr;
    assign w_unused_addr = ^i_addr_lo;

    always_comb begin
        o_wr      = |i_wen;
        o_size    = SZ_WORD;
        o_addr_lo = 2'b00;
        case (i_wen)
            4'b0011: begin o_size = SZ_HALF; o_addr_lo = 2'b00; end
            4'b1100: begin o_size = SZ_HALF; o_addr_lo = 2'b10; end
            4'b0001: begin o_size = SZ_BYTE; o_addr_lo = 2'b00; end
            4'b0010: begin o_size = SZ_BYTE; o_addr_lo = 2'b01; end
            4'b0100: begin o_size = SZ_BYTE; o_addr_lo = 2'b10; end
            4'b1000: begin o_size = SZ_BYTE; o_addr_lo = 2'b11; end
            // reads, full words and illegal masks all issue as aligned words
            default: begin o_size = SZ_WORD; o_addr_lo = 2'b00; end
        endcase
    end

endmodule

// File: rtl/dmem_sram_responder.sv
// Data-port responder: captures the MEM-stage access and runs one split-handshake bus transfer.
// Stall is high from request until DONE; DONE parks while the global stall holds the request.
module dmem_sram_responder
    import dmem_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TRANSLATE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_sram_responder_if.slave  bus
);

    state_t        r_state;
    logic          r_req;
    logic          r_wr;
    logic [1:0]    r_size;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_wstrb;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;

    logic [AW-1:0] w_phys;
    logic [1:0]    w_size;
    logic [1:0]    w_addr_lo;
    logic          w_wr;

    always_comb begin
        w_phys = bus.cpu_addr;
        if (TRANSLATE != 0 && bus.cpu_addr[AW-1 -: 2] == KSEG_TOP2)
            w_phys[AW-1 -: 3] = KSEG_CLEAR;
    end

    dmem_size_enc u_size_enc (
        .i_wen     (bus.cpu_wen),
        .i_addr_lo (bus.cpu_addr[1:0]),
        .o_size    (w_size),
        .o_addr_lo (w_addr_lo),
        .o_wr      (w_wr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wstrb <= 4'd0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cpu_en) begin
                        r_wr    <= w_wr;
                        r_size  <= w_size;
                        r_addr  <= {w_phys[AW-1:2], w_addr_lo};
                        r_wstrb <= bus.cpu_wen;
                        r_wdata <= bus.cpu_wdata;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    // a lone data_ok here cannot belong to us; only addr_ok advances
                    if (bus.mem_addr_ok) begin
                        r_req <= 1'b0;
                        if (bus.mem_data_ok) begin
                            if (!r_wr)
                                r_rdata <= bus.mem_rdata;
                            r_state <= DONE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_data_ok) begin
                        if (!r_wr)
                            r_rdata <= bus.mem_rdata;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.longest_stall)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_stall = bus.cpu_en & (r_state != DONE);
    assign bus.cpu_rdata = r_rdata;
    assign bus.mem_req   = r_req;
    assign bus.mem_wr    = r_wr;
    assign bus.mem_size  = r_size;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wstrb = r_wstrb;
    assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Directed bench for dmem_sram_responder: drives core requests and a scripted bus responder.
module tb_dmem_sram_responder;

    logic clk;
    logic rst;

    dmem_sram_responder_if bus ();

    dmem_sram_responder #(.AW(32), .DW(32), .TRANSLATE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus protocol assertions: legal masks only, and data_ok only for the outstanding transfer
    logic outstanding;
    always @(posedge clk) begin
        if (rst) begin
            outstanding <= 1'b0;
        end else begin
            if (bus.cpu_en)
                assert (bus.cpu_wen inside {4'b0000, 4'b1111, 4'b0011, 4'b1100,
                                            4'b0001, 4'b0010, 4'b0100, 4'b1000})
                    else $error("illegal byte mask %b", bus.cpu_wen);
            if (bus.mem_data_ok)
                assert (outstanding || (bus.mem_req && bus.mem_addr_ok))
                    else $error("data_ok with nothing outstanding");
            if (bus.mem_req && bus.mem_addr_ok && !bus.mem_data_ok)
                outstanding <= 1'b1;
            else if (bus.mem_data_ok)
                outstanding <= 1'b0;
        end
    end

    logic        cap_wr;
    logic [1:0]  cap_size;
    logic [31:0] cap_addr;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_wdata;
    int          stall_cyc, done_cyc, hs_cnt, req_after, unstable;
    bit          finished;

    // cyc 0 is the cycle cpu_en rises; addr_ok/data_ok pulse on the given cycle numbers
    task automatic do_txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input int aok, input int dok, input int ls_hold, input logic [31:0] rdata);
        int  cyc;
        int  dcnt;
        bit  have_cap;
        bit  hs_done;
        cyc = 0; dcnt = 0; have_cap = 0; hs_done = 0; finished = 0;
        stall_cyc = 0; done_cyc = 0; hs_cnt = 0; req_after = 0; unstable = 0;
        while (!finished && cyc < 200) begin
            @(posedge clk); #1;
            bus.cpu_en        = 1'b1;
            bus.cpu_wen       = wen;
            bus.cpu_addr      = addr;
            bus.cpu_wdata     = wdata;
            bus.mem_addr_ok   = (cyc == aok);
            bus.mem_data_ok   = (cyc == dok);
            bus.mem_rdata     = (cyc == dok) ? rdata : 32'h5A5A_5A5A;
            bus.longest_stall = (ls_hold > 0) && (dcnt < ls_hold);
            #1;
            if (bus.cpu_stall) begin
                stall_cyc++;
            end else begin
                done_cyc++;
                dcnt++;
                if (!bus.longest_stall) finished = 1;
            end
            if (bus.mem_req) begin
                if (hs_done) req_after++;
                if (!have_cap) begin
                    have_cap = 1;
                    cap_wr = bus.mem_wr; cap_size = bus.mem_size; cap_addr = bus.mem_addr;
                    cap_wstrb = bus.mem_wstrb; cap_wdata = bus.mem_wdata;
                end else if (cap_wr !== bus.mem_wr || cap_size !== bus.mem_size ||
                             cap_addr !== bus.mem_addr || cap_wstrb !== bus.mem_wstrb ||
                             cap_wdata !== bus.mem_wdata) begin
                    unstable++;
                end
                if (bus.mem_addr_ok) begin
                    hs_cnt++;
                    hs_done = 1;
                end
            end
            cyc++;
        end
        @(posedge clk); #1;
        bus.cpu_en = 1'b0; bus.cpu_wen = 4'd0;
        bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.longest_stall = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1;
        bus.cpu_en = 1'b0; bus.cpu_wen = 4'd0; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
        bus.longest_stall = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0;
        bus.mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check_eq("rst_rdata", bus.cpu_rdata, 32'd0);
        check_eq("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        rst = 1'b0;

        // 1: word read through kseg0, addr_ok cyc1, data_ok cyc3
        do_txn(4'b0000, 32'h8000_1000, 32'h0, 1, 3, 0, 32'hDEAD_BEEF);
        check_eq("t1_done", {31'd0, finished}, 32'd1);
        check_eq("t1_addr", cap_addr, 32'h0000_1000);
        check_eq("t1_size", {30'd0, cap_size}, 32'd2);
        check_eq("t1_wr", {31'd0, cap_wr}, 32'd0);
        check_eq("t1_wstrb", {28'd0, cap_wstrb}, 32'd0);
        check_eq("t1_stall_cyc", stall_cyc, 32'd4);
        check_eq("t1_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t1_rdata_held", bus.cpu_rdata, 32'hDEAD_BEEF);
        check_eq("t1_idle_req", {31'd0, bus.mem_req}, 32'd0);

        // 2: byte write through kseg1, lane 2
        do_txn(4'b0100, 32'hA000_0022, 32'h00AB_0000, 1, 2, 0, 32'h1111_2222);
        check_eq("t2_wr", {31'd0, cap_wr}, 32'd1);
        check_eq("t2_size", {30'd0, cap_size}, 32'd0);
        check_eq("t2_addr", cap_addr, 32'h0000_0022);
        check_eq("t2_wstrb", {28'd0, cap_wstrb}, 32'h4);
        check_eq("t2_wdata", cap_wdata, 32'h00AB_0000);
        check_eq("t2_stall_cyc", stall_cyc, 32'd3);
        check_eq("t2_rdata_kept", bus.cpu_rdata, 32'hDEAD_BEEF);

        // 3: same-cycle addr_ok/data_ok read
        do_txn(4'b0000, 32'h0000_0010, 32'h0, 1, 1, 0, 32'h1234_5678);
        check_eq("t3_stall_cyc", stall_cyc, 32'd2);
        check_eq("t3_handshakes", hs_cnt, 32'd1);
        check_eq("t3_rdata", bus.cpu_rdata, 32'h1234_5678);

        // 4: global stall holds DONE for 5 cycles with cpu_en still high
        do_txn(4'b0000, 32'h0000_0104, 32'h0, 1, 2, 5, 32'hCAFE_F00D);
        check_eq("t4_done", {31'd0, finished}, 32'd1);
        check_eq("t4_done_cyc", done_cyc, 32'd6);
        check_eq("t4_req_after", req_after, 32'd0);
        check_eq("t4_handshakes", hs_cnt, 32'd1);
        check_eq("t4_rdata", bus.cpu_rdata, 32'hCAFE_F00D);
        #1;
        check_eq("t4_idle_req", {31'd0, bus.mem_req}, 32'd0);

        // 5: upper-half write, addr_ok withheld for 6 REQ cycles
        do_txn(4'b1100, 32'h8000_0202, 32'hBEEF_0000, 7, 7, 0, 32'h0);
        check_eq("t5_unstable", unstable, 32'd0);
        check_eq("t5_handshakes", hs_cnt, 32'd1);
        check_eq("t5_stall_cyc", stall_cyc, 32'd8);
        check_eq("t5_size", {30'd0, cap_size}, 32'd1);
        check_eq("t5_addr", cap_addr, 32'h0000_0202);
        check_eq("t5_wstrb", {28'd0, cap_wstrb}, 32'hC);

        // 6: reset while in WAIT
        @(posedge clk); #1;
        bus.cpu_en = 1'b1; bus.cpu_wen = 4'd0; bus.cpu_addr = 32'h0000_0040;
        @(posedge clk); #1;
        bus.mem_addr_ok = 1'b1;
        @(posedge clk); #1;
        bus.mem_addr_ok = 1'b0;
        #1;
        check_eq("t6_wait_req", {31'd0, bus.mem_req}, 32'd0);
        check_eq("t6_wait_stall", {31'd0, bus.cpu_stall}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; bus.cpu_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("t6_rst_req", {31'd0, bus.mem_req}, 32'd0);
        check_eq("t6_rst_rdata", bus.cpu_rdata, 32'd0);
        do_txn(4'b0000, 32'h0000_0040, 32'h0, 1, 2, 0, 32'h0BAD_CAFE);
        check_eq("t6_after_stall", stall_cyc, 32'd3);
        check_eq("t6_after_rdata", bus.cpu_rdata, 32'h0BAD_CAFE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
